// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants, FSM state type and active-low hex-to-
//                seven-segment table for the seven-segment scan path.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int         FRAME_W   = 16;
  localparam int         DIGITS    = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       DP_OFF    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  // Active-low segments, bit order gfedcba, indexed by nibble value.
  // Listed from entry 15 (F) down to entry 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational nibble to active-low seven-segment pattern
//                (bit order gfedcba).
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_sched
//  Description : Eight-digit seven-segment scan scheduler. Snapshots the
//                display value at the start of each pass and emits one
//                {dp, seg, sel} frame per digit over a valid/ready handshake
//                at a programmable refresh rate.
//                Optional build macro LEADING_ZERO_BLANK_EN blanks digits
//                above the most significant non-zero nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50_000,
  parameter int FRAME_W  = seg_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [31:0]        display_data,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [2:0]         digit_idx,
  output logic               overrun
);

  localparam int                 c_CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_TICK_MAX = c_CNT_W'(SCAN_DIV - 1);

  // Registered state
  logic [c_CNT_W-1:0] r_tick_cnt;
  state_t             r_state;
  logic [2:0]         r_digit_idx;
  logic [31:0]        r_shadow;
  logic [15:0]        r_frame;
  logic               r_pending;
  logic               r_overrun;

  // Next-state and frame-build wires
  logic               w_tick;
  state_t             w_state_nxt;
  logic [2:0]         w_digit_nxt;
  logic               w_pending_nxt;
  logic               w_overrun_nxt;
  logic               w_build;
  logic [2:0]         w_build_idx;
  logic               w_load_shadow;
  logic [31:0]        w_src;
  logic [3:0]         w_nibble;
  logic [6:0]         w_seg_raw;
  logic [6:0]         w_seg;
  logic [15:0]        w_frame_built;

  // Free-running refresh divider; held at zero while scanning is disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (!en || (r_tick_cnt == c_TICK_MAX)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_CNT_W'(1);
    end
  end

  assign w_tick = en && (r_tick_cnt == c_TICK_MAX);

  // A frame for digit 0 starts a new pass, so it reads the live display
  // value that is simultaneously captured into the shadow register.
  assign w_load_shadow = w_build && (w_build_idx == 3'd0);
  assign w_src         = w_load_shadow ? display_data : r_shadow;
  assign w_nibble      = w_src[{w_build_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (w_nibble),
    .seg    (w_seg_raw)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] w_top_digit;

  // Locate the most significant non-zero nibble; digit 0 is always shown
  always_comb begin
    w_top_digit = 3'd0;
    for (int k = 1; k < DIGITS; k++) begin
      if (w_src[4*k +: 4] != 4'h0) begin
        w_top_digit = 3'(k);
      end
    end
  end

  assign w_seg = (w_build_idx > w_top_digit) ? SEG_BLANK : w_seg_raw;
`else
  assign w_seg = w_seg_raw;
`endif

  assign w_frame_built = {DP_OFF, w_seg, ~(8'b1 << w_build_idx)};

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, digit sequencing, pending tick and overrun bookkeeping
  always_comb begin
    w_state_nxt   = r_state;
    w_digit_nxt   = r_digit_idx;
    w_pending_nxt = r_pending;
    w_overrun_nxt = r_overrun;
    w_build       = 1'b0;
    w_build_idx   = r_digit_idx;

    case (r_state)
      IDLE: begin
        w_digit_nxt   = 3'd0;
        w_pending_nxt = 1'b0;
        if (en) begin
          w_state_nxt = WAIT;
        end else begin
          w_overrun_nxt = 1'b0;
        end
      end

      WAIT: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_digit_nxt = 3'd0;
        end else if (w_tick) begin
          w_build     = 1'b1;
          w_state_nxt = SEND;
        end
      end

      SEND: begin
        // A tick while the frame is outstanding is remembered once
        if (w_tick) begin
          w_pending_nxt = 1'b1;
          w_overrun_nxt = 1'b1;
        end
        // valid never drops without a transfer, so en is only honoured here
        if (frame_ready) begin
          w_digit_nxt   = r_digit_idx + 3'd1;
          w_pending_nxt = 1'b0;
          if (!en) begin
            w_state_nxt = IDLE;
            w_digit_nxt = 3'd0;
          end else if (r_pending || w_tick) begin
            w_build     = 1'b1;
            w_build_idx = r_digit_idx + 3'd1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_digit_nxt = 3'd0;
      end
    endcase
  end

  // Datapath registers: digit index, shadow snapshot, frame, flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit_idx <= 3'd0;
      r_shadow    <= 32'd0;
      r_frame     <= 16'hFFFF;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_digit_idx <= w_digit_nxt;
      r_pending   <= w_pending_nxt;
      r_overrun   <= w_overrun_nxt;
      if (w_load_shadow) begin
        r_shadow <= display_data;
      end
      if (w_build) begin
        r_frame <= w_frame_built;
      end
    end
  end

  assign frame_data  = FRAME_W'(r_frame);
  assign frame_valid = (r_state == SEND);
  assign digit_idx   = r_digit_idx;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_sched
//  Description : Self-checking bench for seg_scan_sched with SCAN_DIV=4.
//                Directed scenarios followed by randomized en/ready/data,
//                all compared against a transaction-level reference model.
//                Honours LEADING_ZERO_BLANK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_sched;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] display_data;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  digit_idx;
  logic        overrun;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg_scan_sched #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .display_data (display_data),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .digit_idx    (digit_idx),
    .overrun      (overrun)
  );

  // Reference segment patterns, active-low gfedcba, nibble 0 first
  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  int          m_cnt;
  bit          m_on;
  bit          m_busy;
  bit          m_pend;
  bit          m_ovr;
  int          m_digit;
  logic [31:0] m_shadow;
  logic [15:0] m_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [15:0] make_frame(input logic [31:0] v, input int d);
    int         nib;
    logic [6:0] seg;
    logic [7:0] sel;
    nib = int'((v >> (4 * d)) & 32'hF);
    seg = seg_lut[nib];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int top;
      top = 0;
      for (int k = 0; k < 8; k++)
        if (((v >> (4 * k)) & 32'hF) != 0) top = k;
      if (d > top) seg = 7'h7F;
    end
`endif
    sel = 8'hFF ^ 8'(1 << d);
    return {1'b1, seg, sel};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_on = 0; m_busy = 0; m_pend = 0; m_ovr = 0;
    m_digit = 0; m_shadow = 32'd0; m_frame = 16'hFFFF;
  endtask

  task automatic issue();
    if (m_digit == 0) m_shadow = display_data;
    m_frame = make_frame(m_shadow, m_digit);
    m_busy  = 1;
  endtask

  // One clock of behaviour, using the inputs presented before the edge
  task automatic model_step();
    bit tick;
    bit pend_in;
    tick  = en && (m_cnt == SCAN_DIV - 1);
    m_cnt = en ? (m_cnt + 1) % SCAN_DIV : 0;
    if (!m_on) begin
      m_digit = 0;
      m_pend  = 0;
      if (en) m_on = 1;
      else    m_ovr = 0;
    end else if (!m_busy) begin
      if (!en) begin
        m_on = 0; m_digit = 0;
      end else if (tick) begin
        issue();
      end
    end else begin
      pend_in = m_pend || tick;
      if (tick) m_ovr = 1;
      m_pend = pend_in;
      if (frame_ready) begin
        m_digit = (m_digit + 1) % 8;
        m_pend  = 0;
        if (!en) begin
          m_on = 0; m_busy = 0; m_digit = 0;
        end else if (pend_in) begin
          issue();
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("valid",   32'(frame_valid), 32'(m_busy));
    chk("frame",   32'(frame_data),  32'(m_frame));
    chk("digit",   32'(digit_idx),   32'(m_digit));
    chk("overrun", 32'(overrun),     32'(m_ovr));
  endtask

  // Advance one clock: model updates at the edge, DUT compared mid-cycle
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; frame_ready = 1'b0; display_data = 32'd0;
    model_reset();
    #1;
    chk("rst_frame", 32'(frame_data),  32'h0000_FFFF);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    cycle(); cycle();
    reset = 1'b0;
    cycle();

    // Always-ready sink with a fixed value; pin digits 0 and 7 exactly
    display_data = 32'h1234_ABCD; frame_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (m_busy && m_digit == 0) chk("d0_frame", 32'(frame_data), 32'h0000_A1FE);
      if (m_busy && m_digit == 7) chk("d7_frame", 32'(frame_data), 32'h0000_F97F);
    end

    // Change the value partway through a pass
    for (int i = 0; i < 6; i++) cycle();
    display_data = 32'h8765_4321;
    for (int i = 0; i < 40; i++) cycle();

    // Stall the sink long enough for ticks to pile up
    frame_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("ovr_set", 32'(overrun), 32'd1);
    frame_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();

    // Drop en while a frame is outstanding
    frame_ready = 1'b0;
    for (int i = 0; i < 20 && !m_busy; i++) cycle();
    chk("send_reached", 32'(frame_valid), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("hold_valid", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("idle_valid", 32'(frame_valid), 32'd0);
    chk("idle_digit", 32'(digit_idx),   32'd0);
    chk("idle_ovr",   32'(overrun),     32'd0);

`ifdef LEADING_ZERO_BLANK_EN
    display_data = 32'h0000_0042; en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (m_busy && m_digit == 0) chk("lz_d0", 32'(frame_data[14:8]), 32'h24);
      if (m_busy && m_digit == 1) chk("lz_d1", 32'(frame_data[14:8]), 32'h19);
      if (m_busy && m_digit >= 2) chk("lz_blank", 32'(frame_data[14:8]), 32'h7F);
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en          = ($urandom_range(0, 19) != 0);
      frame_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 29) == 0) display_data = $urandom;
      cycle();
    end

    // Asynchronous reset in the middle of a handshake
    en = 1'b1; frame_ready = 1'b0;
    for (int i = 0; i < 20 && !m_busy; i++) cycle();
    chk("pre_rst_valid", 32'(frame_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_frame", 32'(frame_data),  32'h0000_FFFF);
    chk("arst_digit", 32'(digit_idx),   32'd0);
    chk("arst_ovr",   32'(overrun),     32'd0);
    model_reset();
    cycle();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_sched.md
Name: seg_scan_sched

Overview:
- Scan scheduler for the 8-digit seven-segment display path. It snapshots a 32-bit display value and steps through its 8 hex digits at a programmable refresh rate.
- For each digit it emits one 16-bit frame {dp, seg, sel} to the HC595 serializer over a valid/ready handshake.
- It sits between the CPU result bus and the HC595 serializer, and owns the display refresh timing.

Parameters:
- SCAN_DIV, 50_000, clk cycles between digit advances; minimum 2.
- FRAME_W, 16, frame width; fixed at 16, exposed for the package only.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  scan enable.
- display_data  input  32  value to show; nibble k drives digit k.
- frame_data  output  16  {dp, seg[6:0], sel[7:0]}.
- frame_valid  output  1  frame_data valid.
- frame_ready  input  1  serializer accepts the frame.
- digit_idx  output  3  digit currently scheduled.
- overrun  output  1  sticky flag: a tick arrived while a frame was still unaccepted.

Behaviour:
Interface and reset
- Reset (asynchronous, active-high) values: frame_data=16'hFFFF, frame_valid=0, digit_idx=0, overrun=0. Reset also clears the tick counter and the shadow register, and puts the FSM in IDLE.
- Reset asserted mid-handshake drops frame_valid immediately.

Tick counter
- Counts 0..SCAN_DIV-1 while en=1, then wraps to 0.
- tick=1 on the cycle the count equals SCAN_DIV-1.
- Free-running: not stalled by the handshake. Held at 0 while en=0.

FSM states: IDLE, WAIT, SEND.
- IDLE: frame_valid=0, digit_idx=0. Moves to WAIT when en=1.
- WAIT, on tick:
  - If digit_idx=0, load the shadow register from display_data. The shadow changes only at pass start, so there is no tearing within a pass.
  - Register frame_data and go to SEND.
  - frame_valid rises the cycle after the tick (latency 1).
- SEND: frame_valid=1, and frame_data is held stable until frame_valid && frame_ready. On that handshake:
  - digit_idx advances, wrapping 7 to 0.
  - If en=0, go to IDLE.
  - Else if a tick is pending, build the next frame immediately and stay in SEND.
  - Else go to WAIT.
- Tick arriving in SEND:
  - Set the pending bit (single-deep; further ticks are dropped).
  - Set overrun=1. overrun clears only on reset, or on en=0 in IDLE.
- Tick and handshake in the same cycle: the handshake completes, and the tick counts as pending.
- en falling in SEND is honoured only after the handshake, since valid must never drop without a transfer. en falling in WAIT returns to IDLE next cycle.

Frame format
- dp=1 (off).
- sel = ~(8'b1 << digit_idx), active-low one-hot.
- seg is active-low, bit order gfedcba, encoded from the hex nibble. Examples: 0=7'h40, 1=7'h79, 2=7'h24, 8=7'h00, A=7'h08, F=7'h0E.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits above the highest non-zero nibble of the shadow register get seg=7'h7F (blank). Digit 0 is never blanked, so shadow=0 shows a single "0".
- Undefined: all 8 digits always show their nibble, including leading zeros.

Decomposition:
- Package seg_pkg holds:
  - FRAME_W=16, DIGITS=8, SEG_BLANK=7'h7F, DP_OFF=1'b1.
  - The state enum {IDLE, WAIT, SEND}.
  - The 16-entry active-low hex-to-segment constant table.
- One sub-module, hex_to_seg7: combinational 4-bit nibble to seg[6:0], using the package table.

Test Plan:
All scenarios use SCAN_DIV=4.
1. Reset assertion mid-scan, always-ready sink:
   - Reset asserted -> frame_data=16'hFFFF, frame_valid=0 asynchronously.
2. display_data=32'h1234_ABCD, frame_ready tied 1:
   - Frames every 4 cycles.
   - Digit 0 = {1, 7'h21, 8'hFE} (D).
   - Digit 7 = {1, 7'h79, 8'h7F} (1).
   - After digit 7, digit_idx wraps to 0.
3. Shadow coherency: change display_data mid-pass:
   - Remaining digits of the current pass keep the old nibbles.
   - The new value appears from the next digit 0.
4. frame_ready held 0 for 10 cycles:
   - frame_valid and frame_data stay stable.
   - overrun=1.
   - On release, the next frame follows on the cycle after the handshake.
5. en dropped while in SEND:
   - frame_valid holds until the handshake, then IDLE and digit_idx=0.
   - No further frames are sent.
6. LEADING_ZERO_BLANK_EN defined, display_data=32'h0000_0042:
   - Digits 2..7 have seg=7'h7F.
   - Digit 1 seg=7'h19, digit 0 seg=7'h24.
